uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-stream command parser sitting directly downstream of the UART receiver. It consumes the receiver's `rx_data`/`rx_data_ready` byte strobes and assembles fixed-length framed commands (sync, opcode, 16-bit address, 32-bit data, XOR checksum). It presents each verified command on a valid/ready interface to the register/control logic of the MPEG2 core. Malformed, stalled or uncollectable frames are dropped and flagged with single-cycle error pulses.

## Interface
- `CLK_FRE`, default 50: clock frequency in MHz.
- `TIMEOUT_US`, default 1000: maximum inter-byte gap inside a frame, in µs.
- `SYNC_BYTE`, default 8'h55: frame start marker.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_data_ready`=1.
- `rx_data_ready`  in  1  single-cycle byte strobe.
- `cmd_valid`  out  1  command available; held until accepted.
- `cmd_ready`  in  1  consumer accepts the command when `cmd_valid`=1 and `cmd_ready`=1.
- `cmd_op`  out  8  opcode.
- `cmd_addr`  out  16  address, big-endian on the wire.
- `cmd_data`  out  32  data, big-endian on the wire.
- `err_csum`  out  1  one-cycle pulse: checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse: gap exceeded mid-frame.
- `err_overflow`  out  1  one-cycle pulse: good frame dropped because output still occupied.

## Operation
- The frame is 9 bytes: SYNC, OP, A1, A0, D3, D2, D1, D0, CS.
- CS must equal the XOR of bytes OP through D0. SYNC is excluded.
- The FSM uses the following states. Each transition fires only on a `rx_data_ready` cycle unless noted otherwise.
  - S_SYNC: a byte equal to SYNC_BYTE moves to S_HDR. Any other byte is ignored silently.
  - S_HDR: captures OP, A1, A0 using a 3-bit byte index 0..2, then moves to S_DATA.
  - S_DATA: captures D3..D0 using index 0..3, then moves to S_CSUM.
  - S_CSUM: compares the incoming byte against the running XOR.
    - Mismatch: pulse `err_csum` and return to S_SYNC.
    - Match while `cmd_valid`=0: load the output registers, set `cmd_valid`, return to S_SYNC.
    - Match while `cmd_valid`=1 and not being accepted in this same cycle: drop the frame, pulse `err_overflow`, return to S_SYNC.
- Running XOR: cleared on the SYNC byte, then XORed with each byte OP..D0.
- Working registers are separate from the output registers. Parsing of the next frame proceeds while a command awaits acceptance.
- Output registers (`cmd_op`, `cmd_addr`, `cmd_data`) stay stable while `cmd_valid`=1.
- `cmd_valid` clears on the handshake cycle.
- If the handshake and a good checksum byte occur in the same cycle, the new command loads and `cmd_valid` stays 1. No overflow is flagged.
- A SYNC_BYTE value appearing inside a frame is treated as ordinary data. There is no resynchronisation.
- Timeout:
  - Counter width is 32 bits. Terminal count is CLK_FRE*TIMEOUT_US−1.
  - The counter resets on every `rx_data_ready`, and is held at 0 in S_SYNC.
  - Reaching terminal count in any state other than S_SYNC pulses `err_timeout` and returns to S_SYNC.
  - If `rx_data_ready` arrives on the terminal-count cycle, the byte wins: it is processed and no timeout occurs.

## Timing
- Reset values:
  - `cmd_valid`=0.
  - `cmd_op`=0, `cmd_addr`=0, `cmd_data`=0.
  - All `err_*`=0.
  - FSM in S_SYNC, XOR=0, byte index=0, timeout counter=0.
- Asserting reset mid-frame discards the partial frame and any pending command.
- Latency:
  - `cmd_valid` rises, with outputs updated, on the clock edge after the cycle in which CS is presented on `rx_data_ready`.
  - `err_csum` and `err_overflow` pulse on the same edge as that `cmd_valid` rise would occur.
  - `err_timeout` pulses on the edge after terminal count.
- Every `err_*` output is high for exactly one cycle per event. Error outputs are registered.
- Back-to-back bytes on consecutive cycles are accepted. There is no throughput limit below 1 byte per clock.

## Test plan
- Frame 55 01 12 34 DE AD BE EF CS=(01^12^34^DE^AD^BE^EF) with `cmd_ready`=1 -> one-cycle `cmd_valid` with op=01, addr=1234, data=DEADBEEF; no errors.
- Same frame with CS corrupted by XOR 0x01 -> `err_csum` pulse; `cmd_valid` stays 0; a following good frame decodes correctly.
- Bytes 00 FF 55 followed by the remaining 8 frame bytes -> leading garbage ignored; command decoded.
- With CLK_FRE=1 and TIMEOUT_US=10, send 55 01 12 then idle 10 cycles -> `err_timeout` after the 10th idle cycle; a fresh frame then decodes. Repeat with a byte arriving on cycle 10 -> no timeout.
- Hold `cmd_ready`=0 and send two good frames -> first command held stable, `err_overflow` on the second CS. Then raise `cmd_ready` on the same cycle as a third frame's CS -> third command loads and `cmd_valid` stays 1.
- Assert `rst_n`=0 after byte A1 of a frame, release, then send a full frame -> all outputs return to reset values; the new frame decodes; the partial frame produces no output.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Frame parser for UART byte strobes: SYNC OP A1 A0 D3 D2 D1 D0 CS -> valid/ready command.
// Drops bad, stalled or uncollectable frames and reports each one with a registered error pulse.
module uart_cmd_parser #(
  parameter int          CLK_FRE    = 50,
  parameter int          TIMEOUT_US = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        err_csum,
  output logic        err_timeout,
  output logic        err_overflow
);

  localparam logic [31:0] TERM_CNT = 32'(CLK_FRE * TIMEOUT_US - 1);

  typedef enum logic [1:0] {S_SYNC, S_HDR, S_DATA, S_CSUM} state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [7:0]  xor_q;
  logic [31:0] tmo_q;
  logic [7:0]  op_w_q;
  logic [15:0] addr_w_q;
  logic [31:0] data_w_q;
  logic        valid_q;
  logic [7:0]  op_q;
  logic [15:0] addr_q;
  logic [31:0] data_q;
  logic        err_csum_q;
  logic        err_timeout_q;
  logic        err_overflow_q;

  logic [7:0]  xor_d;
  logic        handshake_d;
  logic        tmo_hit_d;

  assign xor_d       = xor_q ^ rx_data;
  assign handshake_d = valid_q & cmd_ready;
  assign tmo_hit_d   = (state_q != S_SYNC) && !rx_data_ready && (tmo_q == TERM_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SYNC;
      idx_q          <= '0;
      xor_q          <= '0;
      tmo_q          <= '0;
      op_w_q         <= '0;
      addr_w_q       <= '0;
      data_w_q       <= '0;
      valid_q        <= 1'b0;
      op_q           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      err_csum_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      err_csum_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      if (handshake_d) valid_q <= 1'b0;

      if (rx_data_ready) begin
        tmo_q <= '0;
        case (state_q)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state_q <= S_HDR;
              xor_q   <= '0;
              idx_q   <= '0;
            end
          end
          S_HDR: begin
            xor_q <= xor_d;
            case (idx_q)
              3'd0:    op_w_q         <= rx_data;
              3'd1:    addr_w_q[15:8] <= rx_data;
              default: addr_w_q[7:0]  <= rx_data;
            endcase
            if (idx_q == 3'd2) begin
              idx_q   <= '0;
              state_q <= S_DATA;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_DATA: begin
            xor_q    <= xor_d;
            data_w_q <= {data_w_q[23:0], rx_data};
            if (idx_q == 3'd3) begin
              idx_q   <= '0;
              state_q <= S_CSUM;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_CSUM: begin
            state_q <= S_SYNC;
            idx_q   <= '0;
            if (rx_data != xor_q) begin
              err_csum_q <= 1'b1;
            end else if (!valid_q || cmd_ready) begin
              // An acceptance in this same cycle frees the slot for the new command.
              valid_q <= 1'b1;
              op_q    <= op_w_q;
              addr_q  <= addr_w_q;
              data_q  <= data_w_q;
            end else begin
              err_overflow_q <= 1'b1;
            end
          end
          default: state_q <= S_SYNC;
        endcase
      end else if (tmo_hit_d) begin
        err_timeout_q <= 1'b1;
        state_q       <= S_SYNC;
        idx_q         <= '0;
        tmo_q         <= '0;
      end else if (state_q != S_SYNC) begin
        tmo_q <= tmo_q + 32'd1;
      end
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_op       = op_q;
  assign cmd_addr     = addr_q;
  assign cmd_data     = data_q;
  assign err_csum     = err_csum_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule
